period_to_freq: RTL and testbench

//  Downstream consumer of the 1 ms-resolution period measurement stage.
//  - Captures the 10-bit period (ms) when the measurement stage pulses its done tick.
//  - Converts it to frequency in milli-Hz, FREQ = DVND / prd, using an iterative restoring divider (1 quotient bit/cycle).
//  - Drives a 20-bit result plus a one-cycle valid tick to the display/BCD stage.

---
 rtl/period_to_freq_pkg.sv | 16 +
 rtl/period_to_freq_if.sv | 21 ++
 rtl/period_to_freq_seq_div_core.sv | 50 +++++
 rtl/period_to_freq.sv | 83 ++++++++
 tb/tb_period_to_freq.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/period_to_freq_pkg.sv
// Shared widths, constants and FSM encoding for the period-to-frequency converter.
package period_to_freq_pkg;

  localparam int unsigned DVND   = 1_000_000;
  localparam int unsigned W_DVSR = 10;
  localparam int unsigned W_QUO  = 20;
  localparam int unsigned W_ITER = $clog2(W_QUO + 1);
  localparam int unsigned W_REM  = W_DVSR + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/period_to_freq_if.sv
// Period-in / frequency-out handshake between the measurement stage and the display stage.
interface period_to_freq_if;
  import period_to_freq_pkg::*;

  logic              prd_tick;
  logic [W_DVSR-1:0] prd;
  logic              ready;
  logic [W_QUO-1:0]  freq;
  logic              freq_tick;
  logic              div_zero;

  modport master (
    output prd_tick, prd,
    input  ready, freq, freq_tick, div_zero
  );

  modport slave (
    input  prd_tick, prd,
    output ready, freq, freq_tick, div_zero
  );
endinterface

// File: rtl/period_to_freq_seq_div_core.sv
// Restoring divider datapath: DVND / divisor, one quotient bit per enabled cycle.
module seq_div_core
  import period_to_freq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [W_DVSR-1:0] dvsr_in,
  output logic              last_c,
  output logic [W_QUO-1:0]  quo_c
);

  logic [W_DVSR-1:0] dvsr;
  logic [W_REM-1:0]  rem;
  logic [W_QUO-1:0]  dvnd;
  logic [W_ITER-1:0] iter;

  logic [W_REM:0]    rem_sh;
  logic              ge;
  logic [W_REM-1:0]  rem_nx;

  // dvnd shifts out dividend bits at the top and collects quotient bits at the bottom
  always_comb begin
    rem_sh = {rem, dvnd[W_QUO-1]};
    ge     = rem_sh >= (W_REM+1)'(dvsr);
    rem_nx = ge ? W_REM'(rem_sh - (W_REM+1)'(dvsr)) : W_REM'(rem_sh);
    quo_c  = {dvnd[W_QUO-2:0], ge};
    last_c = (iter == W_ITER'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr <= '0;
      rem  <= '0;
      dvnd <= '0;
      iter <= '0;
    end else if (load) begin
      dvsr <= dvsr_in;
      rem  <= '0;
      dvnd <= W_QUO'(DVND);
      iter <= W_ITER'(W_QUO);
    end else if (en) begin
      rem  <= rem_nx;
      dvnd <= quo_c;
      iter <= iter - W_ITER'(1);
    end
  end

endmodule

// File: rtl/period_to_freq.sv
// Converts a ms period into a mHz frequency; control FSM and registered result outputs.
module period_to_freq
  import period_to_freq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  period_to_freq_if.slave   bus
);

  state_t           state;
  logic             ready_q;
  logic [W_QUO-1:0] freq_q;
  logic             freq_tick_q;
  logic             div_zero_q;

  logic             load_c;
  logic             en_c;
  logic             last_c;
  logic [W_QUO-1:0] quo_c;

  assign load_c = (state == IDLE) && bus.prd_tick && (bus.prd != '0);
  assign en_c   = (state == OP);

  seq_div_core u_div (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .en      (en_c),
    .dvsr_in (bus.prd),
    .last_c  (last_c),
    .quo_c   (quo_c)
  );

  // Result registers move only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      freq_q      <= '0;
      freq_tick_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      freq_tick_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.prd_tick) begin
            ready_q <= 1'b0;
            if (bus.prd == '0) begin
              state       <= DONE;
              freq_q      <= '1;
              div_zero_q  <= 1'b1;
              freq_tick_q <= 1'b1;
            end else begin
              state <= OP;
            end
          end
        end
        OP: begin
          if (last_c) begin
            state       <= DONE;
            freq_q      <= quo_c;
            div_zero_q  <= 1'b0;
            freq_tick_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.freq      = freq_q;
  assign bus.freq_tick = freq_tick_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_period_to_freq.sv
// Directed vector bench for period_to_freq: result values, tick latency, ignore/abort corners.
module tb_period_to_freq;

  logic clk;
  logic reset;

  period_to_freq_if bus ();

  period_to_freq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  prd;
    logic [19:0] freq;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t        vecs [10];
  int          n_vec = 0;
  int          n_err = 0;
  logic [19:0] last_freq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; tick is sampled on the following posedge (cycle 0)
  task automatic pulse_tick(input logic [9:0] p);
    bus.prd      = p;
    bus.prd_tick = 1'b1;
    @(negedge clk);
    bus.prd_tick = 1'b0;
  endtask

  // Issues one tick and checks latency, result, and ready return; ends at the first ready negedge
  task automatic run_op(input logic [9:0] p, input logic [19:0] ef, input logic edz, input int elat);
    int lat;
    lat = 0;
    pulse_tick(p);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) check("ready_low", 32'(bus.ready), 32'(0));
      if (n == 1 && !bus.freq_tick) check("freq_hold", 32'(bus.freq), 32'(last_freq));
      if (bus.freq_tick) begin
        lat = n;
        break;
      end
    end
    check("tick_latency", 32'(lat), 32'(elat));
    check("freq", 32'(bus.freq), 32'(ef));
    check("div_zero", 32'(bus.div_zero), 32'(edz));
    last_freq = ef;
    @(negedge clk);
    check("ready_back", 32'(bus.ready), 32'(1));
    check("tick_single", 32'(bus.freq_tick), 32'(0));
  endtask

  initial begin
    int ticks;
    int lat;
    logic [19:0] seen;

    vecs[0] = '{prd: 10'd1,    freq: 20'd1_000_000, dz: 1'b0, lat: 21};
    vecs[1] = '{prd: 10'd1000, freq: 20'd1000,      dz: 1'b0, lat: 21};
    vecs[2] = '{prd: 10'd3,    freq: 20'd333_333,   dz: 1'b0, lat: 21};
    vecs[3] = '{prd: 10'd1023, freq: 20'd977,       dz: 1'b0, lat: 21};
    vecs[4] = '{prd: 10'd0,    freq: 20'hFFFFF,     dz: 1'b1, lat: 1};
    vecs[5] = '{prd: 10'd500,  freq: 20'd2000,      dz: 1'b0, lat: 21};
    vecs[6] = '{prd: 10'd7,    freq: 20'd142_857,   dz: 1'b0, lat: 21};
    vecs[7] = '{prd: 10'd13,   freq: 20'd76_923,    dz: 1'b0, lat: 21};
    vecs[8] = '{prd: 10'd512,  freq: 20'd1953,      dz: 1'b0, lat: 21};
    vecs[9] = '{prd: 10'd999,  freq: 20'd1001,      dz: 1'b0, lat: 21};

    bus.prd_tick = 1'b0;
    bus.prd      = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(bus.ready), 32'(1));
    check("rst_freq", 32'(bus.freq), 32'(0));
    check("rst_div_zero", 32'(bus.div_zero), 32'(0));
    check("rst_freq_tick", 32'(bus.freq_tick), 32'(0));
    last_freq = '0;

    // Back-to-back: each op starts on the first ready cycle after the previous one
    foreach (vecs[i]) run_op(vecs[i].prd, vecs[i].freq, vecs[i].dz, vecs[i].lat);

    // Tick arriving mid-division is ignored
    ticks = 0;
    lat   = 0;
    seen  = '0;
    pulse_tick(10'd4);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 10) begin
        bus.prd      = 10'd7;
        bus.prd_tick = 1'b1;
      end
      if (n == 11) bus.prd_tick = 1'b0;
      if (bus.freq_tick) begin
        ticks++;
        if (lat == 0) lat = n;
        seen = bus.freq;
      end
    end
    check("ign_ticks", 32'(ticks), 32'(1));
    check("ign_latency", 32'(lat), 32'(21));
    check("ign_freq", 32'(seen), 32'(250_000));
    check("ign_ready", 32'(bus.ready), 32'(1));

    // Reset mid-division aborts with no result tick
    ticks = 0;
    pulse_tick(10'd9);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 12) reset = 1'b1;
      if (n == 13) reset = 1'b0;
      if (bus.freq_tick) ticks++;
      if (n == 13) begin
        check("abort_freq", 32'(bus.freq), 32'(0));
        check("abort_ready", 32'(bus.ready), 32'(1));
        check("abort_div_zero", 32'(bus.div_zero), 32'(0));
      end
    end
    check("abort_ticks", 32'(ticks), 32'(0));
    last_freq = '0;
    run_op(10'd2, 20'd500_000, 1'b0, 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
